pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage ARM pipeline.
- Drives the freeze (hold) inputs of PC/IF_Stage_Reg and the flush inputs of IF_Stage_Reg and ID_Stage_Reg.
- Inserts bubbles on RAW hazards, squashes wrong-path instructions on a taken branch, and freezes the whole pipeline while the data-memory interface is waiting.
- Keeps a memory-timeout watchdog and a saturating stall-cycle performance counter.

---
 rtl/arm_pipe_pkg.sv | 12 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline hazard controller.
package arm_pipe_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// RAW hazard detection between the ID instruction and older EX/MEM writers.
// Build option FORWARDING_EN: with forwarding present only load-use stalls remain.
module hazard_detect #(
  parameter int REG_W = arm_pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] src1_i,
  input  logic [REG_W-1:0] src2_i,
  input  logic             has_src1_i,
  input  logic             has_src2_i,
  input  logic [REG_W-1:0] exe_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_r_en_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_wb_en_i,
  output logic             hazard_o
);

`ifdef FORWARDING_EN
  // MEM-stage results are always forwardable, so they never stall.
  logic unused_mem;
  assign unused_mem = ^{mem_dest_i, mem_wb_en_i};

  assign hazard_o = exe_mem_r_en_i & exe_wb_en_i &
                    ((has_src1_i & (src1_i == exe_dest_i)) |
                     (has_src2_i & (src2_i == exe_dest_i)));
`else
  logic unused_load;
  logic hz1;
  logic hz2;
  assign unused_load = exe_mem_r_en_i;

  assign hz1 = has_src1_i & ((exe_wb_en_i & (src1_i == exe_dest_i)) |
                             (mem_wb_en_i & (src1_i == mem_dest_i)));
  assign hz2 = has_src2_i & ((exe_wb_en_i & (src2_i == exe_dest_i)) |
                             (mem_wb_en_i & (src2_i == mem_dest_i)));
  assign hazard_o = hz1 | hz2;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: RAW bubbles, branch squash, memory-wait freeze with
// timeout watchdog and saturating stall counter. Honours FORWARDING_EN via hazard_detect.
module pipe_hazard_ctrl
  import arm_pipe_pkg::state_e, arm_pipe_pkg::RUN, arm_pipe_pkg::MEM_WAIT, arm_pipe_pkg::FAULT;
#(
  parameter int REG_W       = arm_pipe_pkg::REG_W,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             has_src1,
  input  logic             has_src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             freeze_all,
  output logic             flush_if,
  output logic             flush_id,
  output logic             mem_fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              hazard;
  logic              run_rules;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .src1_i         (src1),
    .src2_i         (src2),
    .has_src1_i     (has_src1),
    .has_src2_i     (has_src2),
    .exe_dest_i     (exe_dest),
    .exe_wb_en_i    (exe_wb_en),
    .exe_mem_r_en_i (exe_mem_r_en),
    .mem_dest_i     (mem_dest),
    .mem_wb_en_i    (mem_wb_en),
    .hazard_o       (hazard)
  );

  always_comb begin
    freeze_front = 1'b0;
    freeze_all   = 1'b0;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    run_rules    = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    fault_d      = fault_q;
    case (state_q)
      RUN: begin
        if (mem_req & ~mem_ready) begin
          freeze_all = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = TO_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          run_rules  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze_all = 1'b1;
          if (wait_cnt_q == TO_LAST) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      FAULT: freeze_all = 1'b1;
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    // A taken branch squashes the ID instruction, so its hazard is moot.
    if (run_rules) begin
      if (branch_taken) begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (hazard) begin
        freeze_front = 1'b1;
        flush_id     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      fault_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      if ((freeze_front | freeze_all) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign mem_fault = fault_q;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int REG_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int TO_W        = 8;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
  logic             has_src1, has_src2, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic             branch_taken, mem_req, mem_ready;
  logic             freeze_front, freeze_all, flush_if, flush_id, mem_fault;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Model: mode 0=running, 1=waiting on memory, 2=faulted.
  int   m_mode, m_waited, m_stalls;
  logic m_fault;
  logic exp_q[$];

  pipe_hazard_ctrl #(
    .REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2),
    .has_src1(has_src1), .has_src2(has_src2),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_front(freeze_front), .freeze_all(freeze_all),
    .flush_if(flush_if), .flush_id(flush_id), .mem_fault(mem_fault),
    .state(state), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit ref_hazard();
`ifdef FORWARDING_EN
    if (!(exe_mem_r_en && exe_wb_en)) return 1'b0;
    return (has_src1 && src1 == exe_dest) || (has_src2 && src2 == exe_dest);
`else
    bit r1, r2;
    r1 = has_src1 && ((exe_wb_en && src1 == exe_dest) || (mem_wb_en && src1 == mem_dest));
    r2 = has_src2 && ((exe_wb_en && src2 == exe_dest) || (mem_wb_en && src2 == mem_dest));
    return r1 || r2;
`endif
  endfunction

  // {freeze_front, freeze_all, flush_if, flush_id}
  function automatic logic [3:0] exp_ctrl();
    if (m_mode == 2) return 4'b0100;
    if (m_mode == 1 && !mem_ready) return 4'b0100;
    if (m_mode == 0 && mem_req && !mem_ready) return 4'b0100;
    if (branch_taken) return 4'b0011;
    if (ref_hazard()) return 4'b1001;
    return 4'b0000;
  endfunction

  function automatic logic [6:0] exp_vec();
    return {exp_ctrl(), 2'(m_mode), m_fault};
  endfunction

  function automatic logic [6:0] got_vec();
    return {freeze_front, freeze_all, flush_if, flush_id, state, mem_fault};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_fault = 1'b0; m_stalls = 0;
  endtask

  task automatic model_tick();
    logic [3:0] c;
    c = exp_ctrl();
    if ((c[3] || c[2]) && m_stalls < CNT_MAX) m_stalls++;
    case (m_mode)
      0: if (mem_req && !mem_ready) begin m_mode = 1; m_waited = 1; end
      1: begin
        if (mem_ready) begin
          m_mode = 0; m_waited = 0;
        end else if (m_waited + 1 == MEM_TIMEOUT) begin
          m_mode = 2; m_fault = 1'b1;
        end else begin
          m_waited++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
    has_src1 = 0; has_src2 = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    checks++;
    if (got_vec() !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", got_vec(), 7'b0);
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (got_vec() !== 7'b0 || stall_cnt !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %b/%0d expected 0/0", got_vec(), stall_cnt);
    end
    tick();
  endtask

  task automatic test_raw();
    logic [3:0] lit;
    int s0;
    idle_inputs();
    src1 = 4'd3; has_src1 = 1; exe_dest = 4'd3; exe_wb_en = 1;
`ifdef FORWARDING_EN
    lit = 4'b0000;
`else
    lit = 4'b1001;
`endif
    s0 = m_stalls;
    @(negedge clk);
    checks++;
    if (got_vec() !== exp_vec() || got_vec() !== {lit, 3'b000}) begin
      errors++; $display("FAIL raw_exe: got %b expected %b", got_vec(), {lit, 3'b000});
    end
    tick();
    @(negedge clk);
    checks++;
    if (stall_cnt !== CNT_W'(s0 + int'(lit[3]))) begin
      errors++; $display("FAIL raw_stall_cnt: got %0d expected %0d", stall_cnt, s0 + int'(lit[3]));
    end
    idle_inputs();
    src2 = 4'd7; has_src2 = 1; mem_dest = 4'd7; mem_wb_en = 1;
    #1;
    checks++;
    if ({freeze_front, flush_id} !== {lit[3], lit[0]}) begin
      errors++; $display("FAIL raw_mem: got %b expected %b", {freeze_front, flush_id}, {lit[3], lit[0]});
    end
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd5; src2 = 4'd5; has_src2 = 1;
    @(negedge clk);
    checks++;
    if (got_vec() !== exp_vec() || got_vec() !== 7'b1001_000) begin
      errors++; $display("FAIL load_use: got %b expected %b", got_vec(), 7'b1001_000);
    end
    tick();
    has_src2 = 0;
    @(negedge clk);
    checks++;
    if (got_vec() !== 7'b0) begin
      errors++; $display("FAIL load_use_no_read: got %b expected %b", got_vec(), 7'b0);
    end
    tick();
  endtask

  task automatic test_branch_hazard();
    idle_inputs();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd5; src2 = 4'd5; has_src2 = 1;
    branch_taken = 1;
    @(negedge clk);
    checks++;
    if (got_vec() !== exp_vec() || got_vec() !== 7'b0011_000) begin
      errors++; $display("FAIL branch_hazard: got %b expected %b", got_vec(), 7'b0011_000);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int s0;
    logic [1:0] st_lit [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
    idle_inputs();
    s0 = m_stalls;
    for (int i = 0; i < 4; i++) exp_q.push_back(i < 3);
    for (int i = 0; i < 4; i++) begin
      mem_req = 1; mem_ready = (i == 3); branch_taken = (i == 1);
      @(negedge clk);
      checks++;
      if (freeze_all !== exp_q.pop_front() || state !== st_lit[i]) begin
        errors++; $display("FAIL mem_wait_%0d: got fa=%b st=%0d", i, freeze_all, state);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL mem_wait_model_%0d: got %b expected %b", i, got_vec(), exp_vec());
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || stall_cnt !== CNT_W'(s0 + 3)) begin
      errors++; $display("FAIL mem_wait_end: got st=%0d cnt=%0d expected 0/%0d", state, stall_cnt, s0 + 3);
    end
    mem_req = 1; mem_ready = 1;
    #1;
    checks++;
    if (got_vec() !== 7'b0) begin
      errors++; $display("FAIL mem_ready_now: got %b expected %b", got_vec(), 7'b0);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [1:0] st_lit [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    idle_inputs();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (state !== st_lit[i] || mem_fault !== (i >= 4) || freeze_all !== 1'b1) begin
        errors++; $display("FAIL timeout_%0d: got st=%0d flt=%b fa=%b", i, state, mem_fault, freeze_all);
      end
      tick();
    end
    mem_ready = 1; branch_taken = 1;
    @(negedge clk);
    checks++;
    if (got_vec() !== 7'b0100_101) begin
      errors++; $display("FAIL fault_sticky: got %b expected %b", got_vec(), 7'b0100_101);
    end
    idle_inputs();
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (got_vec() !== 7'b0 || stall_cnt !== '0) begin
      errors++; $display("FAIL fault_reset: got %b/%0d expected 0/0", got_vec(), stall_cnt);
    end
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    mem_req = 1;
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== '0 || mem_fault !== 1'b0) begin
      errors++; $display("FAIL reset_mid_wait: got st=%0d cnt=%0d", state, stall_cnt);
    end
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    idle_inputs();
    mem_req = 1;
    for (int i = 0; i < CNT_MAX + 8; i++) tick();
    @(negedge clk);
    checks++;
    if (stall_cnt !== CNT_W'(CNT_MAX) || stall_cnt !== CNT_W'(m_stalls)) begin
      errors++; $display("FAIL saturation: got %0d expected %0d", stall_cnt, CNT_MAX);
    end
    @(posedge clk); #1;
    pulse_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2) pulse_reset();
      src1 = REG_W'($urandom_range(0, 3)); src2 = REG_W'($urandom_range(0, 3));
      exe_dest = REG_W'($urandom_range(0, 3)); mem_dest = REG_W'($urandom_range(0, 3));
      has_src1 = 1'($urandom); has_src2 = 1'($urandom);
      exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom); mem_wb_en = 1'($urandom);
      branch_taken = ($urandom_range(0, 5) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec() || stall_cnt !== CNT_W'(m_stalls)) begin
        errors++;
        $display("FAIL random_%0d: got %b/%0d expected %b/%0d", i, got_vec(), stall_cnt, exp_vec(), m_stalls);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raw();
    test_load_use();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
